// File: rtl/seq_booth_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states and Booth digit codes.
package seq_booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit 2 of a digit code marks a negative digit; bits [1:0] give its magnitude.
  typedef enum logic [2:0] {
    DIG_ZERO = 3'b000,
    DIG_POS1 = 3'b001,
    DIG_POS2 = 3'b010,
    DIG_NEG1 = 3'b101,
    DIG_NEG2 = 3'b110
  } booth_dig_t;

  function automatic booth_dig_t booth_decode(input logic [2:0] win);
    booth_dig_t d;
    case (win)
      3'b001, 3'b010: d = DIG_POS1;
      3'b011:         d = DIG_POS2;
      3'b100:         d = DIG_NEG2;
      3'b101, 3'b110: d = DIG_NEG1;
      default:        d = DIG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Combinational Booth partial-product select: 3-bit window and extended multiplicand in,
// W+3-bit two's-complement partial product out; no state, no backpressure.
module booth_pp_sel
  import seq_booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   win,
  input  logic [W+1:0] mcand,
  output logic [W+2:0] pp
);

  localparam int PW = W + 3;

  booth_dig_t       dig;
  logic [PW-1:0]    x1;
  logic [PW-1:0]    x2;
  logic [PW-1:0]    mag;

  assign x1 = {mcand[W+1], mcand};
  assign x2 = {mcand, 1'b0};

  always_comb begin
    dig = booth_decode(win);
    mag = '0;
    case (dig)
      DIG_POS1, DIG_NEG1: mag = x1;
      DIG_POS2, DIG_NEG2: mag = x2;
      default:            mag = '0;
    endcase
    // Negation at full W+3 width keeps -2*(-2^(W-1)) representable.
    pp = dig[2] ? (~mag + {{(PW-1){1'b0}}, 1'b1}) : mag;
  end

endmodule

// File: rtl/seq_booth_mul.sv
// Sequential radix-4 Booth multiplier, one digit per cycle; product valid W/2+1 cycles after accept.
// Valid/ready on both sides: holds the product in DONE until out_ready, accepts only in IDLE.
module seq_booth_mul
  import seq_booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  localparam int N  = W / 2 + 1;
  localparam int CW = $clog2(N + 1);
  localparam int AW = 2 * W + 4;
  localparam int PW = W + 3;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [W+1:0]    a_q;
  logic [W+2:0]    b_q;
  logic [AW-1:0]   acc_q;
  logic [PW-1:0]   pp;
  logic [AW-1:0]   pp_ext;
  logic [CW:0]     shamt;
  logic [AW-1-2*W:0] acc_unused;

  booth_pp_sel #(.W(W)) u_pp_sel (
    .win   (b_q[2:0]),
    .mcand (a_q),
    .pp    (pp)
  );

  assign pp_ext = {{(AW-PW){pp[PW-1]}}, pp};
  assign shamt  = {cnt_q, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= is_signed ? {{2{a[W-1]}}, a} : {2'b00, a};
            // Multiplier carries the implicit zero below its LSB for the first window.
            b_q   <= is_signed ? {{2{b[W-1]}}, b, 1'b0} : {2'b00, b, 1'b0};
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          acc_q <= acc_q + (pp_ext << shamt);
          b_q   <= b_q >> 2;
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Top accumulator bits only absorb the extension headroom; they never reach p.
  assign acc_unused = acc_q[AW-1:2*W];
  assign p          = acc_q[2*W-1:0];

endmodule
